// File: rtl/picorv_mem_arbiter.sv
// Two-master arbiter sharing one PicoRV-style memory port; grant doubles as the FSM state debug view.
// Optional ARB_TIMEOUT_EN: forced completion with TIMEOUT_RDATA after TIMEOUT_CYCLES grant cycles.
module picorv_mem_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int          CNT_W          = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_mem_valid,
  input  logic             m0_mem_instr,
  input  logic [31:0]      m0_mem_addr,
  input  logic [31:0]      m0_mem_wdata,
  input  logic [3:0]       m0_mem_wstrb,
  output logic             m0_mem_ready,
  output logic [31:0]      m0_mem_rdata,
  input  logic             m1_mem_valid,
  input  logic             m1_mem_instr,
  input  logic [31:0]      m1_mem_addr,
  input  logic [31:0]      m1_mem_wdata,
  input  logic [3:0]       m1_mem_wstrb,
  output logic             m1_mem_ready,
  output logic [31:0]      m1_mem_rdata,
  output logic             s_mem_valid,
  output logic             s_mem_instr,
  output logic [31:0]      s_mem_addr,
  output logic [31:0]      s_mem_wdata,
  output logic [3:0]       s_mem_wstrb,
  input  logic             s_mem_ready,
  input  logic [31:0]      s_mem_rdata,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             timeout_err
);

  // Handshake: a master holds valid until its ready pulse; the slave sees valid only while
  // that master is granted, and its ready completes the transfer in the same cycle.
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             inc0, inc1;
  logic             own_m1, own_valid;
  logic             timeout_hit, done_ready;
  logic [31:0]      done_rdata;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  assign own_m1     = (state_q == GRANT1);
  assign own_valid  = own_m1 ? m1_mem_valid : m0_mem_valid;
  assign done_ready = s_mem_ready | timeout_hit;
  // A real slave ready always wins over a coincident timeout
  assign done_rdata = (timeout_hit && !s_mem_ready) ? TIMEOUT_RDATA : s_mem_rdata;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    inc0         = 1'b0;
    inc1         = 1'b0;
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    case (state_q)
      IDLE: begin
        if (m0_mem_valid && m1_mem_valid)
          state_d = (FIXED_PRIO || last_q) ? GRANT0 : GRANT1;
        else if (m0_mem_valid)
          state_d = GRANT0;
        else if (m1_mem_valid)
          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (own_m1) begin
          s_mem_valid  = m1_mem_valid;
          s_mem_instr  = m1_mem_instr;
          s_mem_addr   = m1_mem_addr;
          s_mem_wdata  = m1_mem_wdata;
          s_mem_wstrb  = m1_mem_wstrb;
          m1_mem_ready = done_ready;
          m1_mem_rdata = done_rdata;
        end else begin
          s_mem_valid  = m0_mem_valid;
          s_mem_instr  = m0_mem_instr;
          s_mem_addr   = m0_mem_addr;
          s_mem_wdata  = m0_mem_wdata;
          s_mem_wstrb  = m0_mem_wstrb;
          m0_mem_ready = done_ready;
          m0_mem_rdata = done_rdata;
        end
        // Every grant ends in IDLE so the slave always sees a fresh valid edge
        if (s_mem_ready) begin
          state_d = IDLE;
          last_d  = own_m1;
          inc0    = !own_m1;
          inc1    = own_m1;
        end else if (timeout_hit || !own_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (inc0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
      if (inc1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_q;
  logic              terr_q;

  // Grants are always entered from IDLE, where the wait counter sits at zero
  assign timeout_hit = (state_q != IDLE) && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == IDLE) wait_q <= '0;
      else                 wait_q <= wait_q + 1'b1;
      if (timeout_hit && !s_mem_ready) terr_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^{TIMEOUT_RDATA, 32'(TIMEOUT_CYCLES)};
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  assign grant = state_q;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

endmodule

// File: doc/picorv_mem_arbiter.md
Name: picorv_mem_arbiter

Overview:
Two-master arbiter that shares one PicoRV-style memory port (valid/ready/addr/wdata/wstrb/rdata) between master 0 (the RISC-V core) and master 1 (a loader/DMA engine). It sits between the requesters and the memory/stream-mapped slave.
- One grant at a time, held until the slave returns mem_ready.
- Round-robin or fixed-priority tie-break.
- Per-master transaction counters for debug.

Parameters:
FIXED_PRIO, 0, 0 = round-robin on ties; 1 = master 0 always wins ties
CNT_W, 16, width of per-master completed-transaction counters
TIMEOUT_CYCLES, 255, cycles in a grant state before forced completion (used only with ARB_TIMEOUT_EN)
TIMEOUT_RDATA, 32'hDEADBEEF, read data returned on timeout (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m0_mem_valid  in  1  master 0 request
m0_mem_instr  in  1  master 0 instruction-fetch flag
m0_mem_addr  in  32  master 0 address
m0_mem_wdata  in  32  master 0 write data
m0_mem_wstrb  in  4  master 0 byte strobes (0 = read)
m0_mem_ready  out  1  master 0 completion pulse
m0_mem_rdata  out  32  master 0 read data
m1_mem_valid, m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb  in  1/1/32/32/4  master 1 request, same meaning as master 0
m1_mem_ready  out  1  master 1 completion pulse
m1_mem_rdata  out  32  master 1 read data
s_mem_valid  out  1  slave request
s_mem_instr  out  1  slave instruction flag
s_mem_addr  out  32  slave address
s_mem_wdata  out  32  slave write data
s_mem_wstrb  out  4  slave strobes
s_mem_ready  in  1  slave completion
s_mem_rdata  in  32  slave read data
grant  out  2  one-hot current owner ({m1,m0}); 00 = idle
cnt0  out  CNT_W  completed master-0 transactions
cnt1  out  CNT_W  completed master-1 transactions
timeout_err  out  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Clock and reset: clk is the only clock. resetn is asynchronous, active-low.
- Reset values: state = IDLE, grant = 00, last = 1 (so master 0 wins the first tie), cnt0 = cnt1 = 0, timeout_err = 0. All outputs are 0 during reset.
- FSM states:
  - IDLE -> GRANT0 or GRANT1 at the next clk edge when any m*_mem_valid = 1. This is a 1-cycle arbitration latency.
  - Only one requester -> grant it.
  - Both requesting -> if FIXED_PRIO = 1, grant master 0; otherwise grant the master != last.
- In GRANTx:
  - s_mem_valid, instr, addr, wdata and wstrb are combinational copies of master x. They are 0 in IDLE.
  - The non-granted master sees ready = 0 and rdata = 0.
- Completion in GRANTx when s_mem_ready = 1:
  - Same cycle: mx_mem_ready = 1 and mx_mem_rdata = s_mem_rdata (combinational pass-through, no extra latency).
  - Next edge: state = IDLE, last = x, cntx += 1.
- Minimum spacing: one IDLE cycle between consecutive grants. This guarantees s_mem_valid drops after every ready pulse, so the slave sees a fresh valid rising edge for each transaction.
- Abort: if mx_mem_valid falls while in GRANTx without s_mem_ready, go to IDLE next edge. No counter increment, last is unchanged.
- Stray ready: s_mem_ready while in IDLE is ignored; no master ready is driven.
- Counters: cnt0 and cnt1 saturate at all-ones; they do not wrap.
- Reset mid-transaction: immediate return to IDLE. A pending slave ready is not forwarded.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to GRANTx and increments each cycle in GRANTx.
  - If it reaches TIMEOUT_CYCLES without s_mem_ready: mx_mem_ready = 1 and mx_mem_rdata = TIMEOUT_RDATA that cycle.
  - Next edge: state = IDLE, timeout_err set (sticky until reset), cntx not incremented.
  - If s_mem_ready arrives on the same cycle as the timeout, the real ready wins.
- Undefined: no counter logic; a grant waits forever; timeout_err = 0.

Test Plan:
- Only m0 reads 0x00000100; slave returns ready with rdata 0x12345678 two cycles after s_mem_valid -> m0_mem_ready pulses for 1 cycle with rdata 0x12345678; grant 01 -> 00; cnt0 = 1.
- m0 and m1 both valid in the same cycle after reset, FIXED_PRIO = 0 -> m0 served first, then one IDLE cycle, then m1; repeat with both held -> grants alternate 01, 10, 01; cnt0 = cnt1 after an even number of grants.
- FIXED_PRIO = 1, both requesting continuously for 4 transactions -> all four go to m0; m1 served only once m0_mem_valid drops.
- m1 write to 0x10000008 with wstrb 4'hF, wdata 0xA5A5A5A5 -> s_mem_* mirror m1 exactly; m0 sees ready = 0 and rdata = 0 throughout.
- resetn asserted while in GRANT1 before the slave responds -> grant = 00 immediately, no ready to m1, counters = 0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never ready -> m0_mem_ready pulses on the 8th grant cycle with rdata 0xDEADBEEF; timeout_err = 1 and stays set; cnt0 unchanged.
